// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// memory geometry and the request legality check.
package lsu_pkg;

  localparam int unsigned MEM_DEPTH = 1024;
  localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH);
  localparam int unsigned LOC_AW    = MEM_AW + 2;
  localparam int unsigned ADDR_W    = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  // Captured request control; only the in-range byte address is kept.
  typedef struct packed {
    logic              we;
    logic [2:0]        funct3;
    logic [LOC_AW-1:0] addr;
  } req_ctrl_t;

  // Misaligned, out-of-range or unsupported width/sign code.
  function automatic logic req_is_err(input logic we, input logic [2:0] funct3,
                                      input logic [ADDR_W-1:0] addr);
    logic legal_f3;
    logic misaligned;
    logic out_of_range;
    legal_f3     = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                   (!we && ((funct3 == F3_BU) || (funct3 == F3_HU)));
    misaligned   = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = |addr[1:0];
      default: misaligned = 1'b0;
    endcase
    out_of_range = |addr[ADDR_W-1:LOC_AW];
    return !legal_f3 || misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extract with sign/zero extension for loads, and lane merge for
// sub-word stores, against one memory word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned n = 32
) (
  input  logic [2:0]   funct3_i,
  input  logic [1:0]   offset_i,
  input  logic [n-1:0] rdata_i,
  input  logic [n-1:0] wdata_i,
  output logic [n-1:0] load_data_o_c,
  output logic [n-1:0] merge_data_o_c
);

  logic [4:0]  byte_sh_c;
  logic [4:0]  half_sh_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_sh_c      = {offset_i, 3'b000};
    half_sh_c      = {offset_i[1], 4'b0000};
    byte_c         = rdata_i[byte_sh_c +: 8];
    half_c         = rdata_i[half_sh_c +: 16];
    load_data_o_c  = rdata_i;
    merge_data_o_c = rdata_i;
    // funct3[2] marks the zero-extending variants
    case (funct3_i[1:0])
      F3_B[1:0]: begin
        load_data_o_c = funct3_i[2] ? n'(byte_c) : {{(n-8){byte_c[7]}}, byte_c};
        merge_data_o_c[byte_sh_c +: 8] = wdata_i[7:0];
      end
      F3_H[1:0]: begin
        load_data_o_c = funct3_i[2] ? n'(half_c) : {{(n-16){half_c[15]}}, half_c};
        merge_data_o_c[half_sh_c +: 16] = wdata_i[15:0];
      end
      default: begin
        load_data_o_c  = rdata_i;
        merge_data_o_c = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit in front of a 1024-word memory with
// registered reads; sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned n = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [n-1:0]      req_wdata,
  output logic              resp_valid,
  output logic [n-1:0]      resp_rdata,
  output logic              resp_err,
  output logic              mem_write_enable,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [n-1:0]      mem_write_data,
  input  logic [n-1:0]      mem_read_data
);

  state_e    state_q, state_d;
  req_ctrl_t ctrl_q, ctrl_d;
  logic [n-1:0] wword_q, wword_d;
  logic [n-1:0] rdata_q, rdata_d;
  logic ready_q, ready_d;
  logic valid_q, valid_d;
  logic err_q, err_d;
  logic we_q, we_d;
  logic accept_c;
  logic req_err_c;
  logic [n-1:0] load_c;
  logic [n-1:0] merge_c;

  assign accept_c  = (state_q == ST_IDLE) && req_valid;
  assign req_err_c = req_is_err(req_we, req_funct3, req_addr);

  lsu_align #(.n(n)) u_align (
    .funct3_i       (ctrl_q.funct3),
    .offset_i       (ctrl_q.addr[1:0]),
    .rdata_i        (mem_read_data),
    .wdata_i        (wword_q),
    .load_data_o_c  (load_c),
    .merge_data_o_c (merge_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: full-word stores skip the read, errors go straight to RESP
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_err_c) begin
            state_d = ST_RESP;
          end else if (req_we && (req_funct3 == F3_W)) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP:  state_d = ctrl_q.we ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; outputs are decoded from state_d so they
  // are registered yet line up with the state they belong to
  always_comb begin
    ctrl_d  = ctrl_q;
    wword_d = wword_q;
    rdata_d = rdata_q;
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_RESP);
    we_d    = (state_d == ST_WR);
    err_d   = accept_c && req_err_c;
    if (accept_c) begin
      ctrl_d.we     = req_we;
      ctrl_d.funct3 = req_funct3;
      ctrl_d.addr   = req_addr[LOC_AW-1:0];
      wword_d       = req_wdata;
      rdata_d       = '0;
    end else if (state_q == ST_CAP) begin
      if (ctrl_q.we) begin
        wword_d = merge_c;
      end else begin
        rdata_d = load_c;
      end
    end
  end

  // Captured request and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      wword_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      wword_q <= wword_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      we_q    <= we_d;
    end
  end

  assign req_ready        = ready_q;
  assign resp_valid       = valid_q;
  assign resp_rdata       = rdata_q;
  assign resp_err         = err_q;
  assign mem_write_enable = we_q;
  assign mem_addr         = ctrl_q.addr[LOC_AW-1:2];
  assign mem_write_data   = wword_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected
// responses and writes; monitors compare them as the DUT produces them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write_enable;
  logic [9:0]  mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  load_store_unit #(.n(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .mem_write_enable (mem_write_enable),
    .mem_addr         (mem_addr),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  // Word memory with registered read and a bench-side preload port
  logic [31:0] mem [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (mem_write_enable) mem[mem_addr] <= mem_write_data;
    mem_read_data <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    string       name;
    logic [9:0]  idx;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    mon_off = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Response and write monitors
  always @(negedge clk) begin
    if (rst_n && !mon_off) begin
      if (resp_valid) begin : g_resp
        resp_t e;
        if (resp_q.size() == 0) begin
          check("unexpected_resp", {31'b0, resp_valid}, 32'd0);
        end else begin
          e = resp_q.pop_front();
          check({e.name, "_rdata"}, resp_rdata, e.rdata);
          check({e.name, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
          check({e.name, "_resp_cycle"}, cyc, e.cyc);
        end
      end
      if (mem_write_enable) begin : g_wr
        wr_t w;
        if (wr_q.size() == 0) begin
          check("unexpected_write", {31'b0, mem_write_enable}, 32'd0);
        end else begin
          w = wr_q.pop_front();
          check({w.name, "_wr_addr"}, {22'b0, mem_addr}, {22'b0, w.idx});
          check({w.name, "_wr_data"}, mem_write_data, w.data);
          check({w.name, "_wr_cycle"}, cyc, w.cyc);
        end
      end
    end
  end

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_data = data;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic wait_ready(input string name, output bit ok);
    int b;
    b = 0;
    @(negedge clk);
    while (!req_ready && b < 100) begin
      @(negedge clk);
      b++;
    end
    ok = req_ready;
    if (!ok) check({name, "_ready_timeout"}, {31'b0, req_ready}, 32'd1);
  endtask

  task automatic issue(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                       input logic has_wr, input logic [31:0] exp_wdata, input int wlat,
                       input logic junk);
    bit    ok;
    resp_t r;
    wr_t   w;
    wait_ready(name, ok);
    if (!ok) return;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    r.name = name; r.rdata = exp_rdata; r.err = exp_err; r.cyc = cyc + lat;
    resp_q.push_back(r);
    if (has_wr) begin
      w.name = name; w.idx = addr[11:2]; w.data = exp_wdata; w.cyc = cyc + wlat;
      wr_q.push_back(w);
    end
    @(negedge clk);
    if (junk) begin
      // a competing request while busy must be ignored
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'hDEADDEAD;
      repeat (lat - 1) @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0) && b < 50) begin
      @(negedge clk);
      b++;
    end
    check("drain_resp_queue", resp_q.size(), 32'd0);
    check("drain_write_queue", wr_q.size(), 32'd0);
  endtask

  initial begin : main
    bit ok;
    int c0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = '0; req_wdata = '0;

    preload(10'd5, 32'h8899AABB);
    preload(10'd9, 32'h11223344);
    preload(10'd1023, 32'h7F000000);

    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_we", {31'b0, mem_write_enable}, 32'd0);
    check("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    rst_n = 1'b1;

    //     name        we    f3      addr          wdata          rdata          err  lat wr  wdata_exp     wlat junk
    issue("lb_16",     1'b0, 3'b000, 32'h16,       32'h0,         32'hFFFFFF99,  1'b0, 3, 1'b0, 32'h0,        0, 1'b1);
    issue("lhu_14",    1'b0, 3'b101, 32'h14,       32'h0,         32'h0000AABB,  1'b0, 3, 1'b0, 32'h0,        0, 1'b0);
    issue("lh_16",     1'b0, 3'b001, 32'h16,       32'h0,         32'hFFFF8899,  1'b0, 3, 1'b0, 32'h0,        0, 1'b0);
    issue("lbu_17",    1'b0, 3'b100, 32'h17,       32'h0,         32'h00000088,  1'b0, 3, 1'b0, 32'h0,        0, 1'b0);
    issue("lw_14",     1'b0, 3'b010, 32'h14,       32'h0,         32'h8899AABB,  1'b0, 3, 1'b0, 32'h0,        0, 1'b0);
    issue("sw_20",     1'b1, 3'b010, 32'h20,       32'h12345678,  32'h0,         1'b0, 2, 1'b1, 32'h12345678, 1, 1'b0);
    issue("lw_20",     1'b0, 3'b010, 32'h20,       32'h0,         32'h12345678,  1'b0, 3, 1'b0, 32'h0,        0, 1'b0);
    issue("sb_21",     1'b1, 3'b000, 32'h21,       32'hABCDEFEE,  32'h0,         1'b0, 4, 1'b1, 32'h1234EE78, 3, 1'b0);
    issue("sh_22",     1'b1, 3'b001, 32'h22,       32'h0000BEEF,  32'h0,         1'b0, 4, 1'b1, 32'hBEEFEE78, 3, 1'b0);
    issue("lh_22",     1'b0, 3'b001, 32'h22,       32'h0,         32'hFFFFBEEF,  1'b0, 3, 1'b0, 32'h0,        0, 1'b0);
    issue("lb_fff",    1'b0, 3'b000, 32'hFFF,      32'h0,         32'h0000007F,  1'b0, 3, 1'b0, 32'h0,        0, 1'b0);
    issue("lw_22_mis", 1'b0, 3'b010, 32'h22,       32'h0,         32'h0,         1'b1, 1, 1'b0, 32'h0,        0, 1'b0);
    issue("sw_1000",   1'b1, 3'b010, 32'h1000,     32'hCAFEF00D,  32'h0,         1'b1, 1, 1'b0, 32'h0,        0, 1'b0);
    issue("lh_15_mis", 1'b0, 3'b001, 32'h15,       32'h0,         32'h0,         1'b1, 1, 1'b0, 32'h0,        0, 1'b0);
    issue("sh_23_mis", 1'b1, 3'b001, 32'h23,       32'h1111,      32'h0,         1'b1, 1, 1'b0, 32'h0,        0, 1'b0);
    issue("ld_f3_011", 1'b0, 3'b011, 32'h0,        32'h0,         32'h0,         1'b1, 1, 1'b0, 32'h0,        0, 1'b0);
    issue("st_f3_bu",  1'b1, 3'b100, 32'h20,       32'h55,        32'h0,         1'b1, 1, 1'b0, 32'h0,        0, 1'b0);
    issue("lb_1000",   1'b0, 3'b000, 32'h1000,     32'h0,         32'h0,         1'b1, 1, 1'b0, 32'h0,        0, 1'b0);
    issue("lw_20_chk", 1'b0, 3'b010, 32'h20,       32'h0,         32'hBEEFEE78,  1'b0, 3, 1'b0, 32'h0,        0, 1'b0);
    drain();

    // Reset while an SH sits in its write cycle
    wait_ready("sh_abort", ok);
    if (ok) begin
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h26; req_wdata = 32'h5555;
      c0 = cyc;
      @(negedge clk);
      req_valid = 1'b0;
      mon_off = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("abort_cycle", cyc, c0 + 3);
      check("abort_in_wr", {31'b0, mem_write_enable}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("abort_we_drop", {31'b0, mem_write_enable}, 32'd0);
      check("abort_ready", {31'b0, req_ready}, 32'd1);
      check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("abort_mem_wdata", mem_write_data, 32'd0);
      repeat (2) @(negedge clk);
      check("abort_mem_word9", mem[9], 32'h11223344);
      rst_n = 1'b1;
      mon_off = 1'b0;
    end
    issue("lw_24_post", 1'b0, 3'b010, 32'h24, 32'h0, 32'h11223344, 1'b0, 3, 1'b0, 32'h0, 0, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
